// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 4-bit tt_um ALU: queues (opcode, a, b) commands, drives the ALU
// pins one command at a time, captures result/flags and returns them on a response stream.
module alu_cmd_issuer #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] ENC_KEY     = 8'hAB,
  parameter int         ALU_LATENCY = 1,
  parameter logic [3:0] IDLE_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [7:0] alu_ui_in,
  output logic [7:0] alu_uio_in,
  input  logic [7:0] alu_uo_out,
  input  logic [7:0] alu_uio_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_opcode,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic [7:0] rsp_plain,
  output logic       rsp_enc_err,
  output logic [7:0] err_count,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. A producer
  // holds valid and its payload stable until that edge; ready never depends on valid.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALU_LATENCY + 1) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_LATENCY);
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_ENC = 4'h8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
  state_t state, state_nxt;

  logic [11:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop, capture;
  logic [11:0]   head;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    op_q, a_q, b_q;
  logic          is_enc, is_arith, enc_err_c;
  logic [7:0]    plain_c;
  logic          unused_flags;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wait_cnt == LAST_CNT) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flags are only meaningful for ADD/SUB; ENC results are decrypted and checked here.
  assign is_enc    = (op_q == OP_ENC);
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign plain_c   = is_enc ? (alu_uo_out ^ ENC_KEY) : 8'h00;
  assign enc_err_c = is_enc && (plain_c != {a_q, b_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_ui_in    <= '0;
      alu_uio_in   <= {4'b0, IDLE_OPCODE};
      rsp_opcode   <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_plain    <= '0;
      rsp_enc_err  <= 1'b0;
      err_count    <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        {op_q, a_q, b_q} <= head;
        alu_ui_in        <= head[7:0];
        alu_uio_in       <= {4'b0, head[11:8]};
        wait_cnt         <= '0;
      end else if (capture) begin
        rsp_opcode   <= op_q;
        rsp_result   <= alu_uo_out;
        rsp_carry    <= is_arith && alu_uio_out[6];
        rsp_overflow <= is_arith && alu_uio_out[7];
        rsp_plain    <= plain_c;
        rsp_enc_err  <= enc_err_c;
        alu_ui_in    <= '0;
        alu_uio_in   <= {4'b0, IDLE_OPCODE};
        if (enc_err_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end else if (state == S_ISSUE) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign rsp_valid    = (state == S_RESP);
  assign busy         = !empty || (state != S_IDLE);
  assign dbg_state    = state;
  assign unused_flags = ^alu_uio_out[5:0];

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU stub with optional ENC corruption, a table of
// directed vectors, hand-written multi-cycle sequences and a randomized scoreboard phase.
module tb_alu_cmd_issuer;

  localparam logic [7:0] KEY    = 8'hAB;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_ENC = 4'h8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = '0, cmd_a = '0, cmd_b = '0;
  logic [7:0] alu_ui_in, alu_uio_in;
  logic [7:0] alu_uo_out = 8'h00, alu_uio_out = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_opcode;
  logic [7:0] rsp_result, rsp_plain, err_count;
  logic       rsp_carry, rsp_overflow, rsp_enc_err, busy;
  logic [1:0] dbg_state;

  int checks = 0, errors = 0;
  logic [22:0] exp_q[$];
  int model_err = 0;
  bit sb_en = 0, corrupt = 0;
  int ready_mode = 1;

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ui_in(alu_ui_in), .alu_uio_in(alu_uio_in),
    .alu_uo_out(alu_uo_out), .alu_uio_out(alu_uio_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_opcode(rsp_opcode), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_plain(rsp_plain), .rsp_enc_err(rsp_enc_err),
    .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU stub: {overflow, carry, result} ----------------
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [1:0] junk;
    junk = {a[0], b[0]};
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        return {(a[3] == b[3]) && (s[3] != a[3]), s[4], 4'h0, s[3:0]};
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        return {(a[3] != b[3]) && (s[3] != a[3]), a < b, 4'h0, s[3:0]};
      end
      OP_MUL: return {junk, 8'(a * b)};
      OP_DIV: return {junk, (b == 4'h0) ? 8'h00 : {4'(a / b), 4'(a % b)}};
      OP_AND: return {junk, 4'h0, a & b};
      OP_OR:  return {junk, 4'h0, a | b};
      OP_XOR: return {junk, 4'h0, a ^ b};
      OP_NOT: return {junk, 4'h0, ~a};
      OP_ENC: return {junk, {a, b} ^ KEY};
      default: return {junk, b, a};
    endcase
  endfunction

  logic [9:0] stub_r;
  always @(posedge clk) begin
    stub_r = alu_ref(alu_uio_in[3:0], alu_ui_in[7:4], alu_ui_in[3:0]);
    alu_uo_out  <= stub_r[7:0] ^ {7'b0, corrupt && (alu_uio_in[3:0] == OP_ENC)};
    alu_uio_out <= {stub_r[9:8], 6'b0};
  end

  // Expected response {opcode, result, carry, overflow, plain, enc_err}.
  function automatic logic [22:0] exp_rsp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input bit cor);
    logic [9:0] r;
    logic [7:0] res, plain;
    logic arith, enc;
    r     = alu_ref(op, a, b);
    enc   = (op == OP_ENC);
    arith = (op == OP_ADD) || (op == OP_SUB);
    res   = r[7:0] ^ {7'b0, cor && enc};
    plain = enc ? (res ^ KEY) : 8'h00;
    return {op, res, arith && r[8], arith && r[9], plain, enc && (plain != {a, b})};
  endfunction

  // ---------------- response readiness ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rsp_ready = 1'b0;
      1: rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input int max_wait, output bit ok);
    bit acc;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    ok = 0;
    for (int w = 0; w < max_wait && !ok; w++) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1;
        exp_q.push_back(exp_rsp(op, a, b, corrupt));
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " drained"}, {31'b0, exp_q.size() == 0 && !busy}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [22:0] got, held_val, e;
  bit held = 0;
  int exp_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (sb_en && rsp_valid) begin
      got = {rsp_opcode, rsp_result, rsp_carry, rsp_overflow, rsp_plain, rsp_enc_err};
      check("idle pins", {alu_ui_in, alu_uio_in}, {8'h00, 4'h0, 4'hF});
      if (held) check("stall stable", got, held_val);
      if (rsp_ready) begin
        held = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected response: got %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("rsp", got, e);
          exp_cnt = model_err + int'(e[0]);
          if (exp_cnt > 255) exp_cnt = 255;
          check("err_count", err_count, exp_cnt);
          model_err = exp_cnt;
        end
      end else begin
        held = 1;
        held_val = got;
      end
    end
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [3:0] op, a, b;
    bit         cor;
    logic [7:0] res;
    logic       c, v;
    logic [7:0] plain;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  initial begin
    vec_t vt[10];
    int lat, n_acc;
    bit ok;

    vt[0] = '{OP_ADD, 4'h9, 4'h8, 1'b0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 8'd0};
    vt[1] = '{OP_ADD, 4'h7, 4'h1, 1'b0, 8'h08, 1'b0, 1'b1, 8'h00, 1'b0, 8'd0};
    vt[2] = '{OP_SUB, 4'h3, 4'h5, 1'b0, 8'h0E, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
    vt[3] = '{OP_MUL, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vt[4] = '{OP_DIV, 4'h7, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vt[5] = '{OP_ENC, 4'h3, 4'h5, 1'b0, 8'h9E, 1'b0, 1'b0, 8'h35, 1'b0, 8'd0};
    vt[6] = '{OP_ENC, 4'h3, 4'h5, 1'b1, 8'h9F, 1'b0, 1'b0, 8'h34, 1'b1, 8'd1};
    vt[7] = '{OP_AND, 4'hC, 4'hA, 1'b0, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    vt[8] = '{OP_NOT, 4'h5, 4'h3, 1'b0, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    vt[9] = '{4'hC,   4'h1, 4'h2, 1'b0, 8'h21, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};

    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset ui_in", alu_ui_in, 8'h00);
    check("reset uio_in", alu_uio_in, 8'h0F);
    check("reset err_count", err_count, 0);
    check("reset busy", busy, 0);
    check("reset rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset cmd_ready", cmd_ready, 1);

    // Directed table: one command at a time, rsp_ready high.
    for (int i = 0; i < 10; i++) begin
      corrupt = vt[i].cor;
      cmd_opcode = vt[i].op; cmd_a = vt[i].a; cmd_b = vt[i].b; cmd_valid = 1'b1;
      check($sformatf("tbl%0d cmd_ready", i), cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("tbl%0d latency", i), lat, 3);
      check($sformatf("tbl%0d rsp", i),
            {rsp_opcode, rsp_result, rsp_carry, rsp_overflow, rsp_plain, rsp_enc_err},
            {vt[i].op, vt[i].res, vt[i].c, vt[i].v, vt[i].plain, vt[i].err});
      check($sformatf("tbl%0d err_count", i), err_count, vt[i].cnt);
      @(posedge clk); #1;
    end
    corrupt = 0;
    model_err = 1;
    sb_en = 1;

    // Back-to-back MUL then DIV.
    send(OP_MUL, 4'hF, 4'hF, 4, ok);
    send(OP_DIV, 4'h7, 4'h0, 4, ok);
    drain("b2b", 50);

    // Backpressure: FIFO_DEPTH+1 commands accepted.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3, ok);
      if (ok) n_acc++;
    end
    check("bp accepted", n_acc, 5);
    check("bp cmd_ready", cmd_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 1;
    drain("bp", 100);

    // Reset while a command is in ISSUE with two queued.
    send(OP_ADD, 4'h1, 4'h2, 2, ok);
    send(OP_MUL, 4'h3, 4'h4, 2, ok);
    send(OP_ENC, 4'h5, 4'h6, 2, ok);
    check("pre-reset in ISSUE", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check("arst rsp_valid", rsp_valid, 0);
    check("arst busy", busy, 0);
    check("arst cmd_ready", cmd_ready, 1);
    check("arst pins", {alu_ui_in, alu_uio_in}, 16'h000F);
    check("arst err_count", err_count, 0);
    exp_q.delete();
    model_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post-arst busy", busy, 0);
    send(OP_SUB, 4'h8, 4'h1, 4, ok);
    drain("post-arst", 50);

    // err_count saturation.
    corrupt = 1;
    for (int i = 0; i < 260; i++) begin
      send(OP_ENC, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 20, ok);
      check("sat accept", ok, 1);
    end
    drain("sat", 100);
    check("sat err_count", err_count, 255);
    corrupt = 0;

    // Randomized traffic with random response backpressure.
    ready_mode = 2;
    for (int bt = 0; bt < 4; bt++) begin
      corrupt = bit'($urandom_range(0, 1));
      for (int i = 0; i < 50; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 30, ok);
        check("rand accept", ok, 1);
      end
      drain("rand", 500);
    end
    ready_mode = 1;
    corrupt = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator-side companion to the 4-bit tt_um ALU. Accepts operation commands (opcode, a, b) on a valid/ready stream, buffers them in a small FIFO and drives the ALU pins one command at a time. It waits out the ALU's registered latency, captures the result and flags, and returns them on a valid/ready response stream. For ENC results it also decrypts (XOR with key) and checks the plaintext against the issued operands. It sits between a host/test controller and the ALU core.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
ENC_KEY, 8'hAB, key used to decrypt ENC results; must match ALU key
ALU_LATENCY, 1, ALU clock cycles from input sample to registered output
IDLE_OPCODE, 4'hF, opcode driven when no command in flight (ALU default: result 0, flags 0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_opcode  in  4  ALU opcode
cmd_a  in  4  operand a
cmd_b  in  4  operand b
alu_ui_in  out  8  {a,b} to ALU ui_in
alu_uio_in  out  8  {4'b0, opcode} to ALU uio_in
alu_uo_out  in  8  ALU result
alu_uio_out  in  8  ALU flags: [7] overflow, [6] carry
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_opcode  out  4  opcode of this response
rsp_result  out  8  captured ALU result
rsp_carry  out  1  carry; forced 0 unless opcode ADD/SUB
rsp_overflow  out  1  overflow; forced 0 unless opcode ADD/SUB
rsp_plain  out  8  ENC: result^ENC_KEY; else 0
rsp_enc_err  out  1  ENC: rsp_plain != {a,b}; else 0
err_count  out  8  ENC mismatches, saturates at 255
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n low): FIFO empty; FSM IDLE; alu_ui_in=0; alu_uio_in={4'b0,IDLE_OPCODE}; all rsp_* =0; err_count=0; busy=0; cmd_ready=1 once released. An in-flight command is dropped and not reported.
- Clock: clk is the same clock as the ALU's clk.
- FIFO: push on cmd_valid&cmd_ready. cmd_ready = !full. Push and pop on the same edge are both honoured. There is no push when full; cmd_* is ignored while cmd_ready=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: FIFO non-empty -> pop head at the edge, load alu_ui_in/alu_uio_in, latch opcode/a/b, wait counter=0, go to ISSUE. Otherwise ALU pins stay at the idle values.
- ISSUE: ALU pins held stable for ALU_LATENCY+1 cycles. On the last edge of ISSUE:
  - capture alu_uo_out and alu_uio_out[7:6] into rsp_* with flag masking;
  - compute rsp_plain/rsp_enc_err;
  - increment err_count if rsp_enc_err (saturating);
  - drive ALU pins back to idle values;
  - go to RESP.
- RESP: rsp_valid=1 and all rsp_* stable until rsp_valid&rsp_ready. At that edge: rsp_valid=0 and go to IDLE. Back-to-back: if the FIFO is non-empty at that edge, pop and go directly to ISSUE.
- Latency (ALU_LATENCY=1, empty FIFO, rsp_ready=1): command accepted at edge E0; ALU pins valid after E1; rsp_valid rises after E3. Sustained throughput is 1 command per ALU_LATENCY+2 cycles.
- Capacity: with rsp_ready held low, FIFO_DEPTH+1 commands are accepted (one held in RESP).
- Opcodes: no decode of legal values; unknown opcodes are issued as-is and their captured result is returned unmodified.
- busy = !empty | (state != IDLE).

Test Plan:
- ADD a=9 b=8, rsp_ready=1 -> rsp_valid 3 cycles after accept; rsp_result=0x01, carry=1, overflow=1, plain=0, enc_err=0.
- MUL a=15 b=15, then DIV a=7 b=0 back-to-back -> responses in order: 0xE1 with flags 0, then 0x00 with flags 0; ALU pins return to opcode 0xF between commands.
- ENC a=3 b=5 -> rsp_result=0x9E, rsp_plain=0x35, enc_err=0, err_count stays 0. Then an ALU stub that flips result bit0 -> rsp_enc_err=1, err_count=1.
- Backpressure: rsp_ready=0, 7 commands offered -> 5 accepted, cmd_ready low after 5th; release rsp_ready -> 5 responses in order, rsp_* stable while stalled.
- Reset asserted during ISSUE with 2 queued -> outputs at reset values immediately, no response emitted after release, next command processed normally.
- err_count saturation: 256 corrupted ENC responses -> err_count holds at 255.
